decode_stage: RTL and testbench

Decode/issue stage sitting directly upstream of the register file and downstream of fetch. Each cycle it drives the register file read addresses from the incoming instruction. It checks a 32-entry scoreboard of in-flight destination registers and bypasses a same-cycle writeback into the read data. When operands are final, it latches the instruction and operands into a one-entry output register handed to execute under a valid/ready handshake.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/decode_stage_if.sv | 47 ++++
 rtl/reg_scoreboard.sv | 38 +++
 rtl/decode_stage.sv | 101 ++++++++++
 tb/tb_decode_stage.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, RV32I major opcodes and the
// payload handed from decode to execute.
package cpu_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;
   // Scoreboard lookups per cycle: rs1, rs2 and rd (WAW).
   localparam int unsigned SB_QUERIES = 3;

   typedef enum logic [6:0] {
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111,
      OP_BRANCH = 7'b1100011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_IMM    = 7'b0010011,
      OP_REG    = 7'b0110011
   } opcode_e;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]       xword_t;

   typedef struct packed {
      xword_t    pc;
      xword_t    inst;
      xword_t    rs1_data;
      xword_t    rs2_data;
      reg_addr_t rd_addr;
      logic      rd_wen;
   } ex_payload_t;

endpackage

// File: rtl/decode_stage_if.sv
// Decode stage bus: fetch handshake, register-file read/writeback, flush and
// execute handshake. slave = decode_stage, master = surrounding pipeline.
interface decode_stage_if;
   import cpu_pkg::*;

   logic      i_if_valid;
   xword_t    i_if_inst;
   xword_t    i_if_pc;
   logic      o_if_ready;
   reg_addr_t o_rs1_addr;
   reg_addr_t o_rs2_addr;
   xword_t    i_rs1_data;
   xword_t    i_rs2_data;
   logic      i_wb_wen;
   reg_addr_t i_wb_addr;
   xword_t    i_wb_data;
   logic      i_flush;
   logic      o_ex_valid;
   logic      i_ex_ready;
   xword_t    o_ex_pc;
   xword_t    o_ex_inst;
   xword_t    o_ex_rs1_data;
   xword_t    o_ex_rs2_data;
   reg_addr_t o_ex_rd_addr;
   logic      o_ex_rd_wen;

   modport slave (
      input  i_if_valid, i_if_inst, i_if_pc,
      output o_if_ready, o_rs1_addr, o_rs2_addr,
      input  i_rs1_data, i_rs2_data,
      input  i_wb_wen, i_wb_addr, i_wb_data,
      input  i_flush, i_ex_ready,
      output o_ex_valid, o_ex_pc, o_ex_inst, o_ex_rs1_data, o_ex_rs2_data,
      output o_ex_rd_addr, o_ex_rd_wen
   );

   modport master (
      output i_if_valid, i_if_inst, i_if_pc,
      input  o_if_ready, o_rs1_addr, o_rs2_addr,
      output i_rs1_data, i_rs2_data,
      output i_wb_wen, i_wb_addr, i_wb_data,
      output i_flush, i_ex_ready,
      input  o_ex_valid, o_ex_pc, o_ex_inst, o_ex_rs1_data, o_ex_rs2_data,
      input  o_ex_rd_addr, o_ex_rd_wen
   );

endinterface

// File: rtl/reg_scoreboard.sv
// Busy bit per architectural register for destinations issued to execute.
// Ports: clk/rst (sync, active high); set_en/set_addr marks a destination
// busy; clr_en/clr_addr clears it on writeback; q_addr/q_busy are lookups
// that already see a same-cycle writeback as clearing the bit.
module reg_scoreboard
   import cpu_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        set_en,
   input  reg_addr_t                   set_addr,
   input  logic                        clr_en,
   input  reg_addr_t                   clr_addr,
   input  reg_addr_t [SB_QUERIES-1:0]  q_addr,
   output logic      [SB_QUERIES-1:0]  q_busy
);

   logic [NUM_REGS-1:0] busy;

   // Set is applied after clear so it wins on the same register; x0 never set.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         if (clr_en && clr_addr != '0) busy[clr_addr] <= 1'b0;
         if (set_en && set_addr != '0) busy[set_addr] <= 1'b1;
      end
   end

   // Lookups with writeback bypass.
   always_comb begin
      q_busy = '0;
      for (int i = 0; i < int'(SB_QUERIES); i++) begin
         q_busy[i] = busy[q_addr[i]] && !(clr_en && clr_addr == q_addr[i]);
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Decode/issue stage: drives register-file read addresses, bypasses a
// same-cycle writeback, stalls on scoreboard/in-flight hazards and holds one
// issued instruction for execute under a valid/ready handshake.
// Ports: i_clk, i_rst (sync, active high), bus (decode_stage_if.slave).
module decode_stage
   import cpu_pkg::*;
(
   input  logic           i_clk,
   input  logic           i_rst,
   decode_stage_if.slave  bus
);

   logic [6:0]  op;
   reg_addr_t   rs1, rs2, rd;
   logic        uses_rs1, uses_rs2, rd_wen;
   xword_t      rs1_val, rs2_val;
   logic        hazard;
   logic        if_ready;
   logic        take;

   ex_payload_t ex_q;
   logic        ex_valid_q;

   logic [SB_QUERIES-1:0] sb_busy;

   // Field extraction and operand-use decode.
   always_comb begin
      op       = bus.i_if_inst[6:0];
      rd       = bus.i_if_inst[11:7];
      rs1      = bus.i_if_inst[19:15];
      rs2      = bus.i_if_inst[24:20];
      uses_rs1 = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
      uses_rs2 = (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
      rd_wen   = !(op == OP_STORE || op == OP_BRANCH) && (rd != '0);
   end

   assign bus.o_rs1_addr = rs1;
   assign bus.o_rs2_addr = rs2;

   // Writeback bypass into the operands.
   always_comb begin
      rs1_val = bus.i_rs1_data;
      rs2_val = bus.i_rs2_data;
      if (bus.i_wb_wen && bus.i_wb_addr != '0 && bus.i_wb_addr == rs1) rs1_val = bus.i_wb_data;
      if (bus.i_wb_wen && bus.i_wb_addr != '0 && bus.i_wb_addr == rs2) rs2_val = bus.i_wb_data;
   end

   reg_scoreboard u_sb (
      .clk      (i_clk),
      .rst      (i_rst),
      .set_en   (ex_valid_q && bus.i_ex_ready && ex_q.rd_wen),
      .set_addr (ex_q.rd_addr),
      .clr_en   (bus.i_wb_wen),
      .clr_addr (bus.i_wb_addr),
      .q_addr   ({rd, rs2, rs1}),
      .q_busy   (sb_busy)
   );

   // The held instruction is still pending even if execute takes it now:
   // its busy bit only appears next cycle.
   always_comb begin
      hazard = 1'b0;
      if (uses_rs1 && rs1 != '0 &&
          (sb_busy[0] || (ex_valid_q && ex_q.rd_wen && ex_q.rd_addr == rs1))) hazard = 1'b1;
      if (uses_rs2 && rs2 != '0 &&
          (sb_busy[1] || (ex_valid_q && ex_q.rd_wen && ex_q.rd_addr == rs2))) hazard = 1'b1;
      if (rd_wen &&
          (sb_busy[2] || (ex_valid_q && ex_q.rd_wen && ex_q.rd_addr == rd))) hazard = 1'b1;
   end

   assign if_ready       = !hazard && (!ex_valid_q || bus.i_ex_ready) && !bus.i_flush;
   assign take           = bus.i_if_valid && if_ready;
   assign bus.o_if_ready = if_ready;

   // One-entry output register; flush blocks the latch via if_ready.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ex_valid_q <= 1'b0;
         ex_q       <= '0;
      end else if (take) begin
         ex_valid_q     <= 1'b1;
         ex_q.pc        <= bus.i_if_pc;
         ex_q.inst      <= bus.i_if_inst;
         ex_q.rs1_data  <= rs1_val;
         ex_q.rs2_data  <= rs2_val;
         ex_q.rd_addr   <= rd;
         ex_q.rd_wen    <= rd_wen;
      end else if (bus.i_ex_ready || bus.i_flush) begin
         ex_valid_q <= 1'b0;
      end
   end

   assign bus.o_ex_valid    = ex_valid_q;
   assign bus.o_ex_pc       = ex_q.pc;
   assign bus.o_ex_inst     = ex_q.inst;
   assign bus.o_ex_rs1_data = ex_q.rs1_data;
   assign bus.o_ex_rs2_data = ex_q.rs2_data;
   assign bus.o_ex_rd_addr  = ex_q.rd_addr;
   assign bus.o_ex_rd_wen   = ex_q.rd_wen;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a register-file model and a queue of
// expected issued instructions compared as each one reaches the output.
module tb_decode_stage;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [4:0]  rd;
      logic        wen;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] regs [32];
   exp_t        sb [$];
   exp_t        last;
   int          n_cmp = 0;
   int          n_mis = 0;

   decode_stage_if bus ();

   decode_stage dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Register file: combinational read, x0 reads zero.
   assign bus.i_rs1_data = (bus.o_rs1_addr == 5'd0) ? 32'd0 : regs[bus.o_rs1_addr];
   assign bus.i_rs2_data = (bus.o_rs2_addr == 5'd0) ? 32'd0 : regs[bus.o_rs2_addr];

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] add_i(input int rd, input int rs1, input int rs2);
      return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'b0110011};
   endfunction

   function automatic logic [31:0] store_i(input int imm_lo, input int rs1, input int rs2);
      return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'(imm_lo), 7'b0100011};
   endfunction

   function automatic logic [31:0] model_op(input logic [4:0] a);
      if (bus.i_wb_wen && bus.i_wb_addr != 5'd0 && bus.i_wb_addr == a) return bus.i_wb_data;
      if (a == 5'd0) return 32'd0;
      return regs[a];
   endfunction

   function automatic logic model_wen(input logic [31:0] inst);
      logic [6:0] op;
      op = inst[6:0];
      return !(op == 7'b0100011 || op == 7'b1100011) && (inst[11:7] != 5'd0);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One clock: the register file writes on the edge, single-cycle inputs drop.
   task automatic tick();
      @(posedge clk);
      if (bus.i_wb_wen && bus.i_wb_addr != 5'd0) regs[bus.i_wb_addr] = bus.i_wb_data;
      #1;
      bus.i_if_valid = 1'b0;
      bus.i_wb_wen   = 1'b0;
      bus.i_flush    = 1'b0;
   endtask

   task automatic set_wb(input int addr, input logic [31:0] data);
      bus.i_wb_wen  = 1'b1;
      bus.i_wb_addr = 5'(addr);
      bus.i_wb_data = data;
   endtask

   task automatic chk_fields(input string tag, input exp_t e);
      chk({tag, ".valid"}, 32'(bus.o_ex_valid), 32'd1);
      chk({tag, ".pc"},    bus.o_ex_pc, e.pc);
      chk({tag, ".inst"},  bus.o_ex_inst, e.inst);
      chk({tag, ".rs1"},   bus.o_ex_rs1_data, e.rs1);
      chk({tag, ".rs2"},   bus.o_ex_rs2_data, e.rs2);
      chk({tag, ".rd"},    32'(bus.o_ex_rd_addr), 32'(e.rd));
      chk({tag, ".wen"},   32'(bus.o_ex_rd_wen), 32'(e.wen));
   endtask

   task automatic chk_ex(input string tag);
      if (sb.size() == 0) begin
         n_cmp++;
         n_mis++;
         $error("FAIL %s.sb: observed empty queue expected an entry", tag);
      end else begin
         last = sb.pop_front();
         chk_fields(tag, last);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".valid"}, 32'(bus.o_ex_valid), 32'd0);
      chk({tag, ".pc"},    bus.o_ex_pc, 32'd0);
      chk({tag, ".inst"},  bus.o_ex_inst, 32'd0);
      chk({tag, ".rs1"},   bus.o_ex_rs1_data, 32'd0);
      chk({tag, ".rs2"},   bus.o_ex_rs2_data, 32'd0);
      chk({tag, ".rd"},    32'(bus.o_ex_rd_addr), 32'd0);
      chk({tag, ".wen"},   32'(bus.o_ex_rd_wen), 32'd0);
   endtask

   // Present an instruction for one cycle; check ready before the edge and,
   // when acceptance is expected, the output register after it.
   task automatic issue_step(input string tag, input logic [31:0] inst,
                             input logic [31:0] pc, input logic exp_ready);
      exp_t e;
      bus.i_if_valid = 1'b1;
      bus.i_if_inst  = inst;
      bus.i_if_pc    = pc;
      @(negedge clk);
      chk({tag, ".ready"}, 32'(bus.o_if_ready), 32'(exp_ready));
      if (exp_ready) begin
         e.pc   = pc;
         e.inst = inst;
         e.rs1  = model_op(inst[19:15]);
         e.rs2  = model_op(inst[24:20]);
         e.rd   = inst[11:7];
         e.wen  = model_wen(inst);
         sb.push_back(e);
      end
      tick();
      if (exp_ready) chk_ex(tag);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + 32'(i);
      regs[0] = 32'd0;
      regs[1] = 32'd5;
      regs[2] = 32'd7;
      bus.i_if_valid = 1'b0;
      bus.i_if_inst  = 32'd0;
      bus.i_if_pc    = 32'd0;
      bus.i_wb_wen   = 1'b0;
      bus.i_wb_addr  = 5'd0;
      bus.i_wb_data  = 32'd0;
      bus.i_flush    = 1'b0;
      bus.i_ex_ready = 1'b0;

      // Reset
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk_zero("reset");

      // Back-to-back independent adds
      bus.i_ex_ready = 1'b1;
      issue_step("t1.a", add_i(6, 1, 2), 32'h100, 1'b1);
      issue_step("t1.b", add_i(7, 1, 2), 32'h104, 1'b1);
      issue_step("t1.c", add_i(8, 2, 1), 32'h108, 1'b1);
      tick();
      chk("t1.drain", 32'(bus.o_ex_valid), 32'd0);
      set_wb(6, 32'h66); tick();
      set_wb(7, 32'h77); tick();
      set_wb(8, 32'h88); tick();

      // RAW stall until writeback, then bypass
      issue_step("t2.a",      add_i(3, 1, 2), 32'h110, 1'b1);
      issue_step("t2.stall0", add_i(4, 3, 3), 32'h114, 1'b0);
      issue_step("t2.stall1", add_i(4, 3, 3), 32'h114, 1'b0);
      set_wb(3, 32'h12);
      issue_step("t2.byp",    add_i(4, 3, 3), 32'h114, 1'b1);
      tick();
      set_wb(4, 32'h44); tick();

      // Execute backpressure holds the output register
      bus.i_ex_ready = 1'b0;
      issue_step("t3.a", add_i(9, 1, 2), 32'h200, 1'b1);
      for (int k = 0; k < 3; k++) begin
         issue_step("t3.stall", add_i(10, 1, 2), 32'h204, 1'b0);
         chk_fields("t3.hold", last);
      end
      bus.i_ex_ready = 1'b1;
      issue_step("t3.resume", add_i(10, 1, 2), 32'h204, 1'b1);
      tick();
      set_wb(9, 32'h99);  tick();
      set_wb(10, 32'hAA); tick();

      // x0 destination, x0 reads, store does not mark its rd field busy
      issue_step("t4.x0",    add_i(0, 1, 2),    32'h300, 1'b1);
      issue_step("t4.rdx0",  add_i(11, 0, 0),   32'h304, 1'b1);
      issue_step("t4.st",    store_i(12, 1, 2), 32'h308, 1'b1);
      issue_step("t4.rd12a", add_i(13, 12, 12), 32'h30c, 1'b1);
      issue_step("t4.rd12b", add_i(14, 12, 0),  32'h310, 1'b1);
      tick();
      set_wb(11, 32'hB1); tick();
      set_wb(13, 32'hD1); tick();
      set_wb(14, 32'hE1); tick();

      // Flush of a held instruction, then flush coinciding with acceptance
      bus.i_ex_ready = 1'b0;
      issue_step("t5.a", add_i(15, 1, 2), 32'h400, 1'b1);
      bus.i_flush = 1'b1;
      issue_step("t5.fl", add_i(20, 1, 2), 32'h404, 1'b0);
      chk("t5.fl.valid", 32'(bus.o_ex_valid), 32'd0);
      bus.i_ex_ready = 1'b1;
      issue_step("t5.b", add_i(16, 15, 15), 32'h408, 1'b1);
      bus.i_flush = 1'b1;
      tick();
      chk("t5.flacc.valid", 32'(bus.o_ex_valid), 32'd0);
      issue_step("t5.stall", add_i(17, 16, 0), 32'h40c, 1'b0);
      set_wb(16, 32'hABC);
      issue_step("t5.byp",   add_i(17, 16, 0), 32'h40c, 1'b1);
      tick();
      set_wb(17, 32'h171); tick();

      // Reset with busy[5] set and an instruction held
      issue_step("t6.a", add_i(5, 1, 2),  32'h500, 1'b1);
      issue_step("t6.b", add_i(18, 1, 2), 32'h504, 1'b1);
      rst = 1'b1;
      bus.i_ex_ready = 1'b0;
      tick();
      rst = 1'b0;
      chk_zero("t6.rst");
      bus.i_ex_ready = 1'b1;
      issue_step("t6.x5", add_i(19, 5, 5), 32'h508, 1'b1);
      tick();

      chk("sb.empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
